// File: rtl/clk_div_bank_if.sv
// Config write port and per-channel control/status bundle
// for the programmable clock divider bank.
interface clk_div_bank_if #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 40,
  parameter int BURST_W = 16,
  parameter int CH_W    = 2
);
  logic               cfg_wr;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_half;
  logic [1:0]         cfg_mode;
  logic [BURST_W-1:0] cfg_burst;
  logic               cfg_ready;
  logic [N_CH-1:0]    start;
  logic [N_CH-1:0]    gate;
  logic               sync_all;
  logic [N_CH-1:0]    clk_out;
  logic [N_CH-1:0]    edge_stb;
  logic [N_CH-1:0]    busy;

  modport master (
    output cfg_wr, cfg_ch, cfg_half, cfg_mode, cfg_burst,
    output start, gate, sync_all,
    input  cfg_ready, clk_out, edge_stb, busy
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_half, cfg_mode, cfg_burst,
    input  start, gate, sync_all,
    output cfg_ready, clk_out, edge_stb, busy
  );
endinterface

// File: rtl/clk_div_bank.sv
// N_CH independent half-period dividers on clkDAC_200m with
// shadowed reload at period boundaries, burst/gated modes and sync.
module clk_div_bank #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 40,
  parameter int BURST_W = 16,
  parameter int CH_W    = 2
) (
  input logic           clkDAC_200m,
  input logic           rst,
  clk_div_bank_if.slave bus
);
  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_FREE  = 2'd1;
  localparam logic [1:0] M_BURST = 2'd2;
  localparam logic [1:0] M_GATED = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } st_t;

  logic [N_CH-1:0] pend_v;
  logic            ready;

  // Out-of-range channel indices never match, so they read as not ready.
  always_comb begin
    ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.cfg_ch == CH_W'(i)) ready = ~pend_v[i];
    end
  end

  assign bus.cfg_ready = ready;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    st_t                st_q, st_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [1:0]         mode_q, mode_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               clk_q, clk_d, stb_q;
    logic               pv_q, pv_d;
    logic [CNT_W-1:0]   ph_q;
    logic [1:0]         pm_q;
    logic [BURST_W-1:0] pb_q;
    logic               run, tgl, sync, fall, bnd;
    logic               apply, acc, go;
    logic               busy_o, clk_o, stb_o;

    assign pend_v[i] = pv_q;

    always_ff @(posedge clkDAC_200m) begin
      if (!rst) begin
        st_q   <= S_IDLE;
        cnt_q  <= '0;
        h_q    <= '0;
        mode_q <= M_OFF;
        len_q  <= '0;
        rem_q  <= '0;
        clk_q  <= 1'b0;
        stb_q  <= 1'b0;
        pv_q   <= 1'b0;
        ph_q   <= '0;
        pm_q   <= M_OFF;
        pb_q   <= '0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        h_q    <= h_d;
        mode_q <= mode_d;
        len_q  <= len_d;
        rem_q  <= rem_d;
        clk_q  <= clk_d;
        stb_q  <= clk_d & ~clk_q;
        pv_q   <= pv_d;
        if (acc) begin
          ph_q <= bus.cfg_half;
          pm_q <= bus.cfg_mode;
          pb_q <= bus.cfg_burst;
        end
      end
    end

    always_comb begin
      run    = st_q != S_IDLE;
      tgl    = run && (cnt_q >= h_q);
      sync   = run && bus.sync_all;
      fall   = tgl && clk_q && !sync;
      bnd    = fall || sync;
      apply  = pv_q && (!run || bnd);
      acc    = bus.cfg_wr && ready && (bus.cfg_ch == CH_W'(i));
      go     = 1'b0;
      st_d   = st_q;
      cnt_d  = cnt_q;
      h_d    = h_q;
      mode_d = mode_q;
      len_d  = len_q;
      rem_d  = rem_q;
      clk_d  = clk_q;
      pv_d   = pv_q | acc;

      if (run) begin
        if (sync) begin
          cnt_d = '0;
          clk_d = 1'b0;
        end else if (tgl) begin
          cnt_d = '0;
          clk_d = ~clk_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      if (apply) begin
        // A start in the apply cycle counts only for an idle BURST channel.
        go = (pm_q == M_FREE)
          || (pm_q == M_GATED && bus.gate[i])
          || (pm_q == M_BURST && mode_q == M_BURST && !run
              && bus.start[i] && pb_q != '0);
        pv_d   = 1'b0;
        h_d    = ph_q;
        mode_d = pm_q;
        len_d  = pb_q;
        rem_d  = pb_q;
        cnt_d  = '0;
        clk_d  = 1'b0;
        st_d   = go ? S_RUN : S_IDLE;
      end else begin
        unique case (st_q)
          S_IDLE: begin
            if (mode_q == M_BURST && bus.start[i] && len_q != '0) begin
              st_d  = S_RUN;
              rem_d = len_q;
              cnt_d = '0;
              clk_d = 1'b0;
            end else if (mode_q == M_GATED && bus.gate[i]) begin
              st_d = S_RUN;
            end
          end
          S_RUN: begin
            if (mode_q == M_BURST && bnd) begin
              rem_d = rem_q - BURST_W'(1);
              if (rem_q <= BURST_W'(1)) begin
                st_d  = S_IDLE;
                clk_d = 1'b0;
              end
            end else if (mode_q == M_GATED && !bus.gate[i]) begin
              st_d = fall ? S_IDLE : S_STOP;
            end
          end
          S_STOP: begin
            if (bus.gate[i]) st_d = S_RUN;
            else if (fall)   st_d = S_IDLE;
          end
          default: st_d = S_IDLE;
        endcase
      end
    end

    always_comb begin
      busy_o = st_q != S_IDLE;
      clk_o  = clk_q;
      stb_o  = stb_q;
    end

    assign bus.busy[i]     = busy_o;
    assign bus.clk_out[i]  = clk_o;
    assign bus.edge_stb[i] = stb_o;
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: free run, reload, burst,
// gated stop/resume, sync_all and mid-run reset.
`timescale 1ns/1ps
module tb_clk_div_bank;
  localparam int M_OFF   = 0;
  localparam int M_FREE  = 1;
  localparam int M_BURST = 2;
  localparam int M_GATED = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  clk_div_bank_if bus();

  clk_div_bank dut (
    .clkDAC_200m(clk),
    .rst(rst),
    .bus(bus)
  );

  always #2.5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int h, input int m, input int b);
    bus.cfg_ch    = 2'(ch);
    bus.cfg_half  = 40'(h);
    bus.cfg_mode  = 2'(m);
    bus.cfg_burst = 16'(b);
    bus.cfg_wr    = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic wait_lvl(input int ch, input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.clk_out[ch] !== v && n < 100);
  endtask

  task automatic test_reset();
    bus.cfg_wr = 0; bus.cfg_ch = 0; bus.cfg_half = 0;
    bus.cfg_mode = 0; bus.cfg_burst = 0;
    bus.start = 0; bus.gate = 0; bus.sync_all = 0;
    rst = 0;
    tick(); tick();
    total++;
    if (bus.clk_out !== 4'b0) begin
      bad++; $display("FAIL rst_clk got=%b want=0000", bus.clk_out);
    end
    total++;
    if (bus.edge_stb !== 4'b0 || bus.busy !== 4'b0) begin
      bad++; $display("FAIL rst_stb_busy got=%b/%b want=0/0", bus.edge_stb, bus.busy);
    end
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", bus.cfg_ready);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_free();
    int n;
    wr(0, 4, M_FREE, 0);
    total++;
    if (bus.cfg_ready !== 1'b0) begin
      bad++; $display("FAIL free_pend_ready got=%b want=0", bus.cfg_ready);
    end
    tick();
    total++;
    if (bus.cfg_ready !== 1'b1 || bus.busy[0] !== 1'b1) begin
      bad++; $display("FAIL free_apply got=%b/%b want=1/1", bus.cfg_ready, bus.busy[0]);
    end
    wait_lvl(0, 1'b1, n);
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL free_first_rise got=%0d want=5", n);
    end
    total++;
    if (bus.edge_stb[0] !== 1'b1) begin
      bad++; $display("FAIL free_stb_first got=%b want=1", bus.edge_stb[0]);
    end
    wait_lvl(0, 1'b0, n);
    total++;
    if (n !== 5) begin
      bad++; $display("FAIL free_high got=%0d want=5", n);
    end
    wait_lvl(0, 1'b1, n);
    total++;
    if (n !== 5 || bus.edge_stb[0] !== 1'b1) begin
      bad++; $display("FAIL free_low got=%0d/%b want=5/1", n, bus.edge_stb[0]);
    end
    tick();
    total++;
    if (bus.edge_stb[0] !== 1'b0) begin
      bad++; $display("FAIL free_stb_width got=%b want=0", bus.edge_stb[0]);
    end
  endtask

  task automatic test_reload();
    int n;
    wr(0, 1, M_FREE, 0);
    total++;
    if (bus.cfg_ready !== 1'b0) begin
      bad++; $display("FAIL reload_ready got=%b want=0", bus.cfg_ready);
    end
    wr(0, 7, M_FREE, 0);
    wait_lvl(0, 1'b0, n);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL reload_old_high got=%0d want=2", n);
    end
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL reload_freed got=%b want=1", bus.cfg_ready);
    end
    wait_lvl(0, 1'b1, n);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL reload_low1 got=%0d want=2", n);
    end
    wait_lvl(0, 1'b0, n);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL reload_high1 got=%0d want=2", n);
    end
    wait_lvl(0, 1'b1, n);
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL reload_low2 got=%0d want=2", n);
    end
    wr(0, 0, M_OFF, 0);
    n = 0;
    while (bus.busy[0] !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.busy[0] !== 1'b0 || bus.clk_out[0] !== 1'b0) begin
      bad++; $display("FAIL reload_off got=%b/%b want=0/0", bus.busy[0], bus.clk_out[0]);
    end
  endtask

  task automatic test_burst();
    int rises = 0;
    int first = 0;
    int last = 0;
    int bend = 0;
    wr(1, 2, M_BURST, 3);
    tick();
    total++;
    if (bus.busy[1] !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL burst_idle got=%b/%b want=0/1", bus.busy[1], bus.cfg_ready);
    end
    bus.start[1] = 1'b1;
    tick();
    bus.start[1] = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      bus.start[1] = (t == 7);
      tick();
      if (bus.edge_stb[1] === 1'b1) begin
        rises++;
        if (first == 0) first = t;
        last = t;
      end
      if (bus.busy[1] === 1'b0 && bend == 0) bend = t;
    end
    bus.start[1] = 1'b0;
    total++;
    if (rises !== 3) begin
      bad++; $display("FAIL burst_rises got=%0d want=3", rises);
    end
    total++;
    if (first !== 3 || last !== 15) begin
      bad++; $display("FAIL burst_times got=%0d,%0d want=3,15", first, last);
    end
    total++;
    if (bend !== 18 || bus.clk_out[1] !== 1'b0) begin
      bad++; $display("FAIL burst_end got=%0d/%b want=18/0", bend, bus.clk_out[1]);
    end
  endtask

  task automatic test_gated();
    int rises = 0;
    int last = 0;
    int bend = 0;
    int gaps = 0;
    int n;
    wr(2, 3, M_GATED, 0);
    tick();
    total++;
    if (bus.busy[2] !== 1'b0) begin
      bad++; $display("FAIL gated_idle got=%b want=0", bus.busy[2]);
    end
    bus.gate[2] = 1'b1;
    tick();
    for (int t = 1; t <= 40; t++) begin
      bus.gate[2] = (t < 20);
      tick();
      if (bus.edge_stb[2] === 1'b1) begin
        rises++;
        last = t;
      end
      if (bus.busy[2] === 1'b0 && bend == 0) bend = t;
    end
    total++;
    if (rises !== 3 || last !== 20) begin
      bad++; $display("FAIL gated_rises got=%0d@%0d want=3@20", rises, last);
    end
    total++;
    if (bend !== 24 || bus.clk_out[2] !== 1'b0) begin
      bad++; $display("FAIL gated_stop got=%0d/%b want=24/0", bend, bus.clk_out[2]);
    end
    rises = 0;
    bus.gate[2] = 1'b1;
    tick();
    for (int t = 1; t <= 30; t++) begin
      bus.gate[2] = !(t == 10 || t == 11);
      tick();
      if (bus.edge_stb[2] === 1'b1) begin
        rises++;
        last = t;
      end
      if (bus.busy[2] !== 1'b1) gaps++;
    end
    total++;
    if (rises !== 4 || last !== 28 || gaps !== 0) begin
      bad++; $display("FAIL gated_resume got=%0d@%0d gaps=%0d want=4@28 gaps=0", rises, last, gaps);
    end
    bus.gate[2] = 1'b0;
    n = 0;
    while (bus.busy[2] !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.busy[2] !== 1'b0 || bus.clk_out[2] !== 1'b0) begin
      bad++; $display("FAIL gated_final got=%b/%b want=0/0", bus.busy[2], bus.clk_out[2]);
    end
  endtask

  task automatic test_sync();
    int r0 = 0;
    int r3 = 0;
    int act = 0;
    wr(0, 4, M_FREE, 0);
    wr(3, 9, M_FREE, 0);
    repeat (6) tick();
    total++;
    if (bus.clk_out[0] !== 1'b1) begin
      bad++; $display("FAIL sync_pre got=%b want=1", bus.clk_out[0]);
    end
    bus.sync_all = 1'b1;
    tick();
    bus.sync_all = 1'b0;
    total++;
    if (bus.clk_out !== 4'b0 || bus.busy !== 4'b1001) begin
      bad++; $display("FAIL sync_low got=%b/%b want=0000/1001", bus.clk_out, bus.busy);
    end
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.edge_stb[0] === 1'b1 && r0 == 0) r0 = t;
      if (bus.edge_stb[3] === 1'b1 && r3 == 0) r3 = t;
    end
    total++;
    if (r0 !== 5 || r3 !== 10) begin
      bad++; $display("FAIL sync_rise got=%0d,%0d want=5,10", r0, r3);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (bus.clk_out !== 4'b0 || bus.busy !== 4'b0) begin
      bad++; $display("FAIL rst_mid got=%b/%b want=0/0", bus.clk_out, bus.busy);
    end
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.clk_out !== 4'b0 || bus.busy !== 4'b0) act++;
    end
    total++;
    if (act !== 0 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL rst_idle got=%0d/%b want=0/1", act, bus.cfg_ready);
    end
  endtask

  initial begin
    test_reset();
    test_free();
    test_reload();
    test_burst();
    test_gated();
    test_sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider running on clkDAC_200m. It generates N_CH independent divided clocks (DAC, ADC-write and FIR sample clocks) from one counter-per-channel engine.
- Adds several capabilities: shadowed divisor and mode reload at period boundaries (no runt pulses), burst mode, gated mode, a global phase-align sync and per-channel rising-edge strobes.
- Sits beside the PLL clock generator. It is programmed by the command decoder through a single-channel config write port.

Parameters:
- N_CH, 4, number of output channels (1..16)
- CNT_W, 40, half-period counter and divisor width
- BURST_W, 16, burst period-count width
- CH_W, 2, channel index width (must be at least clog2(N_CH), and at least 1)

Ports:
- clkDAC_200m  in  1  200 MHz clock; all logic is on its rising edge
- rst  in  1  synchronous reset, active-low
- cfg_wr  in  1  config write request
- cfg_ch  in  CH_W  target channel of the write
- cfg_half  in  CNT_W  half-period divisor H
- cfg_mode  in  2  mode: 0 OFF, 1 FREE, 2 BURST, 3 GATED
- cfg_burst  in  BURST_W  number of full periods per burst
- cfg_ready  out  1  pending slot of channel cfg_ch is empty (combinational from cfg_ch)
- start  in  N_CH  per-channel burst start pulse
- gate  in  N_CH  per-channel run enable for GATED mode
- sync_all  in  1  phase-align pulse for all channels
- clk_out  out  N_CH  divided clocks (registered)
- edge_stb  out  N_CH  one-cycle strobe, high in the same cycle clk_out goes 0 to 1
- busy  out  N_CH  channel running (clk_out toggling or a period in progress)

Behaviour:
- Reset (rst=0 at a clock edge):
  - clk_out=0, edge_stb=0, busy=0.
  - All counters 0; active H=0; mode OFF; burst remaining 0.
  - All pending slots empty, so cfg_ready=1.
- Divider core, per channel:
  - While running, if cnt<H then cnt++ and clk_out holds.
  - Otherwise cnt<=0 and clk_out toggles.
  - Toggle interval is H+1 cycles; output period is 2(H+1) cycles; duty is 50%.
  - H=0 gives 100 MHz.
  - cnt is CNT_W bits; comparison is unsigned; no wrap is possible because cnt never exceeds H.
- Period boundary: the cycle in which clk_out toggles 1 to 0.
- Config write:
  - A write is accepted when cfg_wr=1 and cfg_ready=1; it stores {H, mode, burst} into the pending slot of cfg_ch.
  - cfg_wr with cfg_ready=0 is ignored; nothing changes.
  - cfg_ch >= N_CH is ignored, and cfg_ready=0 for that index.
- Pending apply:
  - Idle channel (busy=0): pending is applied in the cycle after acceptance.
  - Running channel: pending is applied at the next period boundary.
  - On apply, cnt<=0 and the slot is freed, so cfg_ready=1 from the next cycle.
  - New mode FREE: channel starts running immediately; the first rise occurs H+1 cycles after apply.
  - New mode OFF: channel stops with clk_out=0 and busy=0.
- State machine, per channel: IDLE, RUN, STOPPING.
  - IDLE to RUN: mode FREE applied; or mode BURST with start=1 and burst>0; or mode GATED with gate=1.
  - RUN, FREE mode: runs until a pending config is applied.
  - RUN, BURST mode: remaining is loaded from burst at start and decrements at each period boundary. When it reaches 0 at a boundary, go to IDLE with clk_out=0.
  - RUN, GATED mode: gate=0 moves to STOPPING. STOPPING completes the current period and enters IDLE at the boundary. gate returning to 1 during STOPPING goes back to RUN without a gap.
  - start is ignored while busy, or when burst=0.
- busy is 1 in RUN and STOPPING, and 0 in IDLE.
- sync_all:
  - Every channel in RUN or STOPPING gets cnt<=0 and clk_out<=0 in the same cycle; channel state is unchanged.
  - Pending slots of running channels are applied in that same cycle.
  - sync_all takes priority over a toggle in that cycle.
  - A boundary caused by sync_all decrements burst remaining.
- Simultaneous events:
  - A config write to a channel in the same cycle its slot applies: the write is rejected, because cfg_ready was 0.
  - start together with a pending apply on an idle channel: the apply happens first; start is honoured only if the mode was already BURST before that cycle.
- Reset mid-operation overrides everything; the next rise after reset requires a new config.

Test Plan:
- Reset, then write ch0 H=4 mode FREE: cfg_ready on ch0 returns to 1 after 1 cycle. clk_out[0] first rises 5 cycles after apply, then has a 10-cycle period. edge_stb[0] is 1 cycle wide every 10 cycles.
- ch0 running with H=4; write H=1 mid-high phase: the old period completes, then the period is 4 cycles. No high or low phase is shorter than 2 cycles. A second write before apply is ignored.
- ch1 BURST with H=2 and burst=3, pulse start: exactly 3 rising edges, each period 6 cycles. busy[1] falls with the final fall. A start sent during the burst adds no edges.
- ch2 GATED with H=3: gate high for 20 cycles, then low. The last period completes, so clk_out[2] ends low at a boundary and busy drops. A gate re-rise during STOPPING continues without a gap.
- ch0 H=4 and ch3 H=9 both FREE, pulse sync_all: both outputs go low in the same cycle and their first rises come 5 and 10 cycles later respectively. The same test with rst pulsed mid-period: all outputs are 0 on the next cycle and the channels stay idle.
